alu_result_stage: RTL and testbench

- Pipeline stage directly downstream of the 64-bit ripple adder/subtracter.
- Registers the adder sum and its carry and overflow outputs.
- Derives the N/Z/C/V flags, holds the architectural flags register, and evaluates branch condition codes.
- Provides valid/ready handshakes on both sides. A 2-entry skid buffer gives full throughput under backpressure.

---
 rtl/alu_result_stage.sv | 124 ++++++++++++
 tb/tb_alu_result_stage.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_stage.sv
// Result stage after the 64-bit adder: registers sum/carry/overflow, derives N/Z/C/V,
// holds the architectural flags, evaluates branch conditions, 2-entry skid buffering.
module alu_result_stage #(
   parameter int          DATA_WIDTH  = 64,
   parameter int          RD_WIDTH    = 5,
   parameter logic [3:0]  FLAGS_RESET = 4'b0000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_sum,
   input  logic                  in_carry,
   input  logic                  in_overflow,
   input  logic                  in_set_flags,
   input  logic [RD_WIDTH-1:0]   in_rd,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_result,
   output logic [RD_WIDTH-1:0]   out_rd,
   output logic [3:0]            out_flags,
   output logic [3:0]            flags,
   input  logic [3:0]            cond,
   output logic                  cond_true
);

   typedef struct packed {
      logic [DATA_WIDTH-1:0] result;
      logic [RD_WIDTH-1:0]   rd;
      logic [3:0]            flags;   // {N,Z,C,V}
   } entry_t;

   entry_t     in_entry;
   entry_t     m_q, m_d, s_q, s_d;
   logic       m_valid_q, m_valid_d;
   logic       s_valid_q, s_valid_d;
   logic       in_ready_q;
   logic [3:0] flags_q, flags_d;
   logic       accept, m_free;

   assign in_entry = '{result: in_sum,
                       rd:     in_rd,
                       flags:  {in_sum[DATA_WIDTH-1], (in_sum == '0), in_carry, in_overflow}};

   assign accept = in_valid & in_ready_q;
   assign m_free = ~m_valid_q | out_ready;

   always_comb begin
      // NOTE: every next-state variable gets its hold value first so no path infers a latch.
      m_d       = m_q;
      m_valid_d = m_valid_q;
      s_d       = s_q;
      s_valid_d = s_valid_q;
      flags_d   = flags_q;
      if (m_free) begin
         if (s_valid_q) begin
            m_d       = s_q;
            m_valid_d = 1'b1;
            s_valid_d = accept;
            if (accept) s_d = in_entry;
         end else begin
            m_valid_d = accept;
            if (accept) m_d = in_entry;
         end
      end else if (accept) begin
         s_d       = in_entry;
         s_valid_d = 1'b1;
      end
      // Flags commit at acceptance, independent of when the entry retires.
      if (accept && in_set_flags) flags_d = in_entry.flags;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         m_q        <= '0;
         m_valid_q  <= 1'b0;
         s_q        <= '0;
         s_valid_q  <= 1'b0;
         in_ready_q <= 1'b0;
         flags_q    <= FLAGS_RESET;
      end else begin
         m_q        <= m_d;
         m_valid_q  <= m_valid_d;
         s_q        <= s_d;
         s_valid_q  <= s_valid_d;
         in_ready_q <= ~s_valid_d;
         flags_q    <= flags_d;
      end
   end

   assign in_ready   = in_ready_q;
   assign out_valid  = m_valid_q;
   assign out_result = m_q.result;
   assign out_rd     = m_q.rd;
   assign out_flags  = m_q.flags;
   assign flags      = flags_q;

   logic f_n, f_z, f_c, f_v;
   assign {f_n, f_z, f_c, f_v} = flags_q;

   always_comb begin
      cond_true = 1'b0;
      unique case (cond)
         4'd0:  cond_true = f_z;
         4'd1:  cond_true = ~f_z;
         4'd2:  cond_true = f_c;
         4'd3:  cond_true = ~f_c;
         4'd4:  cond_true = f_n;
         4'd5:  cond_true = ~f_n;
         4'd6:  cond_true = f_v;
         4'd7:  cond_true = ~f_v;
         4'd8:  cond_true = f_c & ~f_z;
         4'd9:  cond_true = ~f_c | f_z;
         4'd10: cond_true = (f_n == f_v);
         4'd11: cond_true = (f_n != f_v);
         4'd12: cond_true = ~f_z & (f_n == f_v);
         4'd13: cond_true = f_z | (f_n != f_v);
         4'd14: cond_true = 1'b1;
         4'd15: cond_true = 1'b0;
         default: cond_true = 1'b0;
      endcase
   end

endmodule

// File: tb/tb_alu_result_stage.sv
// Scoreboard bench for alu_result_stage: directed adder cases, backpressure, reset, random traffic.
module tb_alu_result_stage;
   localparam int         DW = 64;
   localparam int         RW = 5;
   localparam logic [3:0] FR = 4'b0000;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid, in_ready, in_carry, in_overflow, in_set_flags;
   logic [DW-1:0] in_sum, out_result;
   logic [RW-1:0] in_rd, out_rd;
   logic          out_valid, out_ready, cond_true;
   logic [3:0]    out_flags, flags, cond;

   alu_result_stage #(.DATA_WIDTH(DW), .RD_WIDTH(RW), .FLAGS_RESET(FR)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_sum(in_sum),
      .in_carry(in_carry), .in_overflow(in_overflow), .in_set_flags(in_set_flags),
      .in_rd(in_rd), .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
      .out_rd(out_rd), .out_flags(out_flags), .flags(flags), .cond(cond), .cond_true(cond_true));

   typedef struct packed {
      logic [DW-1:0] result;
      logic [RW-1:0] rd;
      logic [3:0]    flags;
   } exp_t;

   exp_t       sb[$];
   longint     pop_cyc[$];
   longint     cyc = 0;
   int         checks = 0, errors = 0;
   logic [3:0] flags_exp = FR;
   bit         mon_en = 0;
   bit         rand_done;

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h expected=%h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   function automatic logic [3:0] derive(input logic [DW-1:0] s, input logic c, input logic v);
      return {s[DW-1], s == 0, c, v};
   endfunction

   // Conditions come in complementary pairs: bit 0 of the code inverts the base test.
   function automatic logic cond_ref(input logic [3:0] f, input logic [3:0] cc);
      logic n, z, c, v, base;
      {n, z, c, v} = f;
      case (cc[3:1])
         3'd0: base = z;
         3'd1: base = c;
         3'd2: base = n;
         3'd3: base = v;
         3'd4: base = c && !z;
         3'd5: base = (n == v);
         3'd6: base = !z && (n == v);
         default: base = 1'b1;
      endcase
      return base ^ cc[0];
   endfunction

   always @(negedge clk) begin
      if (mon_en && !rst) begin
         if (out_valid) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL spurious_output got rd=%0d expected no output", out_rd);
            end else begin
               check("out_result", out_result, sb[0].result);
               check("out_rd", out_rd, sb[0].rd);
               check("out_flags", out_flags, sb[0].flags);
               if (out_ready) begin
                  void'(sb.pop_front());
                  pop_cyc.push_back(cyc);
               end
            end
         end
         check("flags", flags, flags_exp);
         check("cond_true", cond_true, cond_ref(flags_exp, cond));
      end
   end

   task automatic send(input logic [DW-1:0] s, input logic c, input logic v,
                       input logic set, input logic [RW-1:0] rd);
      bit acc;
      int budget = 0;
      in_valid = 1'b1; in_sum = s; in_carry = c; in_overflow = v;
      in_set_flags = set; in_rd = rd; cond = 4'($urandom_range(0, 15));
      do begin
         acc = in_ready;
         @(posedge clk);
         if (acc) begin
            sb.push_back(exp_t'{s, rd, derive(s, c, v)});
            if (set) flags_exp = derive(s, c, v);
         end
         #1;
         budget++;
      end while (!acc && budget < 200);
      if (!acc) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout got in_ready=0 expected acceptance of rd=%0d", rd);
      end
      in_valid = 1'b0;
   endtask

   task automatic wait_drain(input string name);
      int budget = 0;
      while (sb.size() != 0 && budget < 50) begin
         @(posedge clk); #1;
         budget++;
      end
      check(name, sb.size(), 0);
   endtask

   initial begin
      logic [DW-1:0] s;
      int n;
      rst = 1'b1; in_valid = 1'b0; in_sum = '0; in_carry = 1'b0; in_overflow = 1'b0;
      in_set_flags = 1'b0; in_rd = '0; out_ready = 1'b0; cond = 4'd0;

      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_out_result", out_result, 0);
      check("rst_out_rd", out_rd, 0);
      check("rst_out_flags", out_flags, 0);
      check("rst_flags", flags, FR);
      check("rst_in_ready_low", in_ready, 0);
      rst = 1'b0;
      @(posedge clk); #1;
      check("rst_in_ready_high", in_ready, 1);
      mon_en = 1;
      out_ready = 1'b1;

      // 5 - 3
      send(64'd2, 1'b1, 1'b0, 1'b1, 5'd10);
      check("t1_out_valid", out_valid, 1);
      check("t1_out_result", out_result, 64'd2);
      check("t1_flags", flags, 4'b0010);
      cond = 4'd8;  #1; check("t1_hi", cond_true, 1);
      cond = 4'd0;  #1; check("t1_eq", cond_true, 0);

      // 3 - 5
      send(64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b1, 5'd11);
      check("t2_flags", flags, 4'b1000);
      cond = 4'd11; #1; check("t2_lt", cond_true, 1);
      cond = 4'd3;  #1; check("t2_cc", cond_true, 1);

      // 0x7FFF.. + 1
      send(64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b1, 5'd12);
      check("t3_flags", flags, 4'b1001);
      cond = 4'd10; #1; check("t3_ge", cond_true, 1);
      cond = 4'd6;  #1; check("t3_vs", cond_true, 1);

      // zero result, no flag update
      send(64'd0, 1'b1, 1'b0, 1'b0, 5'd13);
      check("t4_out_flags", out_flags, 4'b0110);
      check("t4_flags_hold", flags, 4'b1001);
      wait_drain("directed_drain");

      // backpressure: rd 1,2 accepted, rd 3 stalls, then 1,2,3 drain back to back
      out_ready = 1'b0;
      pop_cyc.delete();
      send(64'h111, 1'b0, 1'b0, 1'b0, 5'd1);
      send(64'h222, 1'b0, 1'b0, 1'b0, 5'd2);
      check("bp_in_ready_low", in_ready, 0);
      check("bp_out_rd_held", out_rd, 5'd1);
      fork
         send(64'h333, 1'b0, 1'b0, 1'b0, 5'd3);
         begin
            repeat (3) @(posedge clk);
            #1 out_ready = 1'b1;
         end
      join
      wait_drain("bp_drain");
      n = pop_cyc.size();
      check("bp_pop_count", n, 3);
      if (n >= 3) begin
         check("bp_no_bubble_12", pop_cyc[n-2] - pop_cyc[n-3], 1);
         check("bp_no_bubble_23", pop_cyc[n-1] - pop_cyc[n-2], 1);
      end

      // reset with M and S full
      out_ready = 1'b0;
      send(64'h8000_0000_0000_0005, 1'b1, 1'b1, 1'b1, 5'd4);
      send(64'h6, 1'b0, 1'b0, 1'b0, 5'd5);
      check("rst_mid_full", in_ready, 0);
      rst = 1'b1;
      @(posedge clk);
      sb.delete();
      flags_exp = FR;
      #1;
      check("rst_mid_out_valid", out_valid, 0);
      check("rst_mid_flags", flags, FR);
      check("rst_mid_in_ready_low", in_ready, 0);
      rst = 1'b0;
      @(posedge clk); #1;
      check("rst_mid_in_ready_high", in_ready, 1);
      check("rst_mid_out_valid2", out_valid, 0);

      // random traffic with random backpressure
      rand_done = 0;
      fork
         begin
            for (int i = 0; i < 300; i++) begin
               case ($urandom_range(0, 3))
                  0: s = '0;
                  1: s = {$urandom, $urandom};
                  2: s = {1'b1, 31'($urandom), $urandom};
                  default: s = DW'($urandom_range(0, 7));
               endcase
               send(s, 1'($urandom), 1'($urandom), 1'($urandom), RW'($urandom));
               if ($urandom_range(0, 3) == 0) begin
                  @(posedge clk); #1;
               end
            end
            rand_done = 1;
         end
         begin
            while (!rand_done) begin
               @(posedge clk); #1;
               out_ready = ($urandom_range(0, 3) != 0);
            end
         end
      join
      out_ready = 1'b1;
      wait_drain("random_drain");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
